// File: rtl/mdu_pkg.sv
// Purpose : shared MDU encodings used by mdu_ctrl, the E-stage decoder and the hazard unit.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package mdu_pkg;

  // MDU op encoding as produced by the E-stage decoder. 6 and 7 are reserved.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Result of the arithmetic core. wr = 0 means "leave HI/LO untouched".
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } mdu_res_t;

  // MULT/MULTU/DIV/DIVU all have op[2] clear.
  function automatic logic mdu_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // DIV/DIVU have op[1] set within the arithmetic group.
  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[1] == 1'b1);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Purpose : combinational 64-bit multiply/divide core for MULT/MULTU/DIV/DIVU.
// Latency : 0 cycles (pure combinational); mdu_ctrl latches the result.
// Backpressure: none.
//
// Ports:
//   op_i  [2:0]  MDU op; non-arithmetic ops give res_o = '0 (wr = 0)
//   a_i   [31:0] rs operand (dividend / multiplicand)
//   b_i   [31:0] rt operand (divisor / multiplier)
//   res_o        {hi, lo, wr}; hi = remainder / product[63:32], lo = quotient / product[31:0]
//
// Config macro MDU_DIVZERO_DEF_EN: when defined, a divide by zero gives
// hi = a_i, lo = 32'hFFFF_FFFF; when undefined it returns wr = 0 so HI/LO keep
// their previous contents.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output mdu_res_t    res_o
);

  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] prod_s, prod_u;
  logic               b_zero;
  logic        [31:0] b_safe;
  logic        [31:0] a_abs, b_abs, b_abs_safe;
  logic        [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Divisor is forced to 1 when zero so the dividers never see a zero operand;
  // the real divide-by-zero result is chosen below.
  assign b_zero = (b_i == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b_i;
  assign uq     = a_i / b_safe;
  assign ur     = a_i % b_safe;

  // Signed divide on magnitudes. |0x8000_0000| is representable unsigned, so
  // 0x8000_0000 / -1 yields quotient 0x8000_0000, remainder 0 with no overflow trap.
  assign a_abs      = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign b_abs      = b_i[31] ? (~b_i + 32'd1) : b_i;
  assign b_abs_safe = b_zero ? 32'd1 : b_abs;
  assign sq_mag     = a_abs / b_abs_safe;
  assign sr_mag     = a_abs % b_abs_safe;
  // Truncation toward zero: quotient negative when signs differ, remainder follows dividend.
  assign sq         = (a_i[31] ^ b_i[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr         = a_i[31] ? (~sr_mag + 32'd1) : sr_mag;

  always_comb begin
    res_o = '0;
    case (op_i)
      MDU_MULT: begin
        res_o.hi = prod_s[63:32];
        res_o.lo = prod_s[31:0];
        res_o.wr = 1'b1;
      end
      MDU_MULTU: begin
        res_o.hi = prod_u[63:32];
        res_o.lo = prod_u[31:0];
        res_o.wr = 1'b1;
      end
      MDU_DIV: begin
        res_o.hi = sr;
        res_o.lo = sq;
        res_o.wr = 1'b1;
      end
      MDU_DIVU: begin
        res_o.hi = ur;
        res_o.lo = uq;
        res_o.wr = 1'b1;
      end
      default: res_o = '0;
    endcase

    if (mdu_is_div(op_i) && b_zero) begin
`ifdef MDU_DIVZERO_DEF_EN
      res_o.hi = a_i;
      res_o.lo = 32'hFFFF_FFFF;
      res_o.wr = 1'b1;
`else
      res_o = '0;
`endif
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Purpose : E-stage multiply/divide controller; sequences fixed-latency MDU ops and owns HI/LO.
// Latency : MULT/MULTU MULT_CYCLES, DIV/DIVU DIV_CYCLES busy cycles; MTHI/MTLO 1 edge, no busy.
// Backpressure: none inside; hazard unit stalls on (busy | start); starts during RUN are dropped.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears FSM, counter, HI/LO and pending result
//   start          E-stage instruction is an MDU op this cycle
//   op    [2:0]    MDU op encoding (mdu_pkg)
//   A, B  [31:0]   forwarded rs / rt operands
//   busy           registered, high while an op is in flight
//   hi, lo [31:0]  architectural HI/LO
//
// Config macro MDU_DIVZERO_DEF_EN selects the divide-by-zero result (see mdu_calc).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,  // 1..15
  parameter int unsigned DIV_CYCLES  = 10  // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LAT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LAT  = DIV_CYCLES[3:0];

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        p_wr_q, p_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  mdu_res_t    calc_res;

  mdu_calc u_calc (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .res_o (calc_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          if (mdu_is_arith(op)) begin
            // Result is captured at issue so the operands need not be held.
            p_hi_d  = calc_res.hi;
            p_lo_d  = calc_res.lo;
            p_wr_d  = calc_res.wr;
            cnt_d   = mdu_is_div(op) ? DIV_LAT : MULT_LAT;
            state_d = MDU_RUN;
          end else if (op == MDU_MTHI) begin
            hi_d = A;
          end else if (op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - 4'd1;
        // Retire on the last busy cycle so HI/LO are valid when busy drops.
        if (cnt_q == 4'd1) begin
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_wr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose : self-checking bench for mdu_ctrl (scoreboard of expected HI/LO and busy length).
// Latency : n/a.
// Backpressure: n/a.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Issues one op at the current negedge and counts busy cycles until it drops.
  // early is set if HI/LO move while busy is still high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit early);
    logic [31:0] hi0, lo0;
    hi0   = hi;
    lo0   = lo;
    early = 1'b0;
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (hi !== hi0 || lo !== lo0) early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = MDU_MTHI; A = 32'hDEAD_BEEF; B = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    // Reset must win over a MULT start in the same cycle.
    reset = 1'b1; start = 1'b1; op = MDU_MULT; A = 32'd3; B = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy: got %b want 0", busy); end
  endtask

  task automatic test_mult;
    int cyc; bit early; exp_t e;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, cyc, early);
    e = sb.pop_front();
    checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL mult_busy_len: got %0d want %0d", cyc, e.cyc); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL mult_hi: got %h want %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL mult_lo: got %h want %h", lo, e.lo); end
    checks++; if (early) begin errors++; $display("FAIL mult_early_write: got 1 want 0"); end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] ehs [4] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [31:0] els [4] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    int cyc; bit early; exp_t e;
    for (int i = 0; i < 4; i++) begin
      push_exp(ehs[i], els[i], 10);
      run_op(ops[i], as[i], bs[i], cyc, early);
      e = sb.pop_front();
      checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL div%0d_busy_len: got %0d want %0d", i, cyc, e.cyc); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, lo, e.lo); end
    end
  endtask

  task automatic test_mthi_mtlo;
    int cyc; bit early; exp_t e;
    start = 1'b1; op = MDU_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    start = 1'b1; op = MDU_MTLO; A = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo: got %h want cafef00d", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", busy); end

    // MULT with MTLO, MTHI and DIVU starts injected while it runs; all must be dropped.
    push_exp(32'd1, 32'd0, 5);
    early = 1'b0;
    start = 1'b1; op = MDU_MULT; A = 32'h0001_0000; B = 32'h0001_0000;
    @(negedge clk);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D) early = 1'b1;
      if (cyc == 1) begin start = 1'b1; op = MDU_MTLO; A = 32'h0000_DEAD; end
      else if (cyc == 2) begin start = 1'b1; op = MDU_MTHI; A = 32'h0000_BEEF; end
      else if (cyc == 3) begin start = 1'b1; op = MDU_DIVU; A = 32'd9; B = 32'd3; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL run_ignore_busy_len: got %0d want %0d", cyc, e.cyc); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL run_ignore_hi: got %h want %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL run_ignore_lo: got %h want %h", lo, e.lo); end
    checks++; if (early) begin errors++; $display("FAIL run_ignore_hilo_moved: got 1 want 0"); end
  endtask

  task automatic test_back_to_back;
    int c1, c2; bit e1, e2; exp_t x1, x2;
    push_exp(32'd2, 32'd14, 10);
    push_exp(32'd1, 32'hFFFF_FFFE, 5);
    run_op(MDU_DIV, 32'd100, 32'd7, c1, e1);
    x1 = sb.pop_front();
    checks++; if (hi !== x1.hi || lo !== x1.lo) begin errors++; $display("FAIL b2b_div_hilo: got %h_%h want %h_%h", hi, lo, x1.hi, x1.lo); end
    // Issued in the very first non-busy cycle.
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, c2, e2);
    x2 = sb.pop_front();
    checks++; if (c1 !== x1.cyc) begin errors++; $display("FAIL b2b_div_len: got %0d want %0d", c1, x1.cyc); end
    checks++; if (c2 !== x2.cyc) begin errors++; $display("FAIL b2b_multu_len: got %0d want %0d", c2, x2.cyc); end
    checks++; if (hi !== x2.hi || lo !== x2.lo) begin errors++; $display("FAIL b2b_multu_hilo: got %h_%h want %h_%h", hi, lo, x2.hi, x2.lo); end
  endtask

  task automatic test_reset_mid_run;
    bit late;
    start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_started: got %b want 1", busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;               // third busy cycle
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrst_hilo: got %h_%h want 0_0", hi, lo); end
    late = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late = 1'b1;
    end
    checks++; if (late) begin errors++; $display("FAIL midrst_late_write: got 1 want 0"); end
  endtask

  task automatic test_reserved;
    bit moved;
    start = 1'b1; op = MDU_MTHI; A = 32'h1111_1111;
    @(negedge clk);
    op = MDU_MTLO; A = 32'h2222_2222;
    @(negedge clk);
    moved = 1'b0;
    op = 3'd6; A = 32'hFFFF_0000; B = 32'd1;
    @(negedge clk);
    if (busy !== 1'b0) moved = 1'b1;
    op = 3'd7;
    @(negedge clk);
    if (busy !== 1'b0) moved = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (moved || busy !== 1'b0) begin errors++; $display("FAIL reserved_busy: got 1 want 0"); end
    checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL reserved_hilo: got %h_%h want 11111111_22222222", hi, lo); end
  endtask

  task automatic test_divzero;
    int cyc; bit early; exp_t e;
    start = 1'b1; op = MDU_MTHI; A = 32'hAAAA_0000;
    @(negedge clk);
    op = MDU_MTLO; A = 32'h0000_BBBB;
    @(negedge clk);
    start = 1'b0;
`ifdef MDU_DIVZERO_DEF_EN
    push_exp(32'd5, 32'hFFFF_FFFF, 10);
`else
    push_exp(32'hAAAA_0000, 32'h0000_BBBB, 10);
`endif
    run_op(MDU_DIV, 32'd5, 32'd0, cyc, early);
    e = sb.pop_front();
    checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL divzero_busy_len: got %0d want %0d", cyc, e.cyc); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL divzero_hi: got %h want %h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL divzero_lo: got %h want %h", lo, e.lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_run();
    test_reserved();
    test_divzero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
